// File: rtl/buffer_reader_if.sv
// Reader-side bundle for buffer_reader: buffer memory port plus the output stream handshake.
interface buffer_reader_if #(
    parameter int BufferWidth = 2,
    parameter int DataWidth   = 8
);
    logic [BufferWidth-1:0] W_Addr;
    logic                   Round;
    logic [BufferWidth-1:0] R_Addr;
    logic                   Pop;
    logic [DataWidth-1:0]   Mem_RData;
    logic [DataWidth-1:0]   Out_Data;
    logic                   Out_Valid;
    logic                   Out_Ready;
    logic                   Empty;
    logic [BufferWidth:0]   Count;

    modport master (
        input  W_Addr, Round, Mem_RData, Out_Ready,
        output R_Addr, Pop, Out_Data, Out_Valid, Empty, Count
    );

    modport slave (
        output W_Addr, Round, Mem_RData, Out_Ready,
        input  R_Addr, Pop, Out_Data, Out_Valid, Empty, Count
    );
endinterface

// File: rtl/buffer_reader.sv
// Circular-buffer reader feeding a valid/ready stream through a 2-entry skid FIFO.
// Optional BUFFER_READER_PTR_CHECK_EN adds a sticky Ptr_Err pointer-consistency flag.
module buffer_reader #(
    parameter int BufferWidth = 2,
    parameter int DataWidth   = 8
) (
    input  logic             clk,
    input  logic             aclr_n,
    buffer_reader_if.master  bus
`ifdef BUFFER_READER_PTR_CHECK_EN
    ,
    output logic             Ptr_Err
`endif
);
    localparam int unsigned          Depth  = 2 ** BufferWidth;
    localparam logic [BufferWidth:0] DepthW = (BufferWidth + 1)'(Depth);

    typedef enum logic [1:0] {
        SKID_EMPTY,
        SKID_ONE,
        SKID_TWO
    } skid_state_e;

    skid_state_e            skid_q, skid_d;
    logic [BufferWidth-1:0] r_addr_q, r_addr_d;
    logic                   inflight_q, inflight_d;
    logic [DataWidth-1:0]   head_q, head_d;
    logic [DataWidth-1:0]   tail_q, tail_d;

    logic                   empty;
    logic [BufferWidth:0]   count;
    logic                   out_valid;
    logic                   xfer;
    logic [1:0]             held_cnt;
    logic [1:0]             occ;
    logic [1:0]             occ_after;
    logic                   pop;

    always_comb begin
        empty = (r_addr_q == bus.W_Addr) && !bus.Round;
        count = bus.Round ? (DepthW - {1'b0, r_addr_q} + {1'b0, bus.W_Addr})
                          : ({1'b0, bus.W_Addr} - {1'b0, r_addr_q});

        out_valid = (skid_q != SKID_EMPTY);
        xfer      = out_valid && bus.Out_Ready;

        held_cnt = (skid_q == SKID_TWO) ? 2'd2 :
                   (skid_q == SKID_ONE) ? 2'd1 : 2'd0;
        occ       = held_cnt + {1'b0, inflight_q};
        // A word leaving this cycle frees its slot for a read issued now.
        occ_after = occ - {1'b0, xfer};
        pop       = aclr_n && !empty && (occ_after < 2'd2);
    end

    always_comb begin
        r_addr_d   = pop ? r_addr_q + BufferWidth'(1) : r_addr_q;
        inflight_d = pop;
        skid_d     = skid_q;
        head_d     = head_q;
        tail_d     = tail_q;

        unique case (skid_q)
            SKID_EMPTY: begin
                if (inflight_q) begin
                    head_d = bus.Mem_RData;
                    skid_d = SKID_ONE;
                end
            end
            SKID_ONE: begin
                if (xfer && inflight_q) begin
                    head_d = bus.Mem_RData;
                end else if (xfer) begin
                    skid_d = SKID_EMPTY;
                end else if (inflight_q) begin
                    tail_d = bus.Mem_RData;
                    skid_d = SKID_TWO;
                end
            end
            SKID_TWO: begin
                // Read gating guarantees no arrival here unless the head leaves.
                if (xfer) begin
                    head_d = tail_q;
                    if (inflight_q) begin
                        tail_d = bus.Mem_RData;
                    end else begin
                        skid_d = SKID_ONE;
                    end
                end
            end
            default: begin
                skid_d = SKID_EMPTY;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!aclr_n) begin
            skid_q     <= SKID_EMPTY;
            r_addr_q   <= '0;
            inflight_q <= 1'b0;
            head_q     <= '0;
            tail_q     <= '0;
        end else begin
            skid_q     <= skid_d;
            r_addr_q   <= r_addr_d;
            inflight_q <= inflight_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
        end
    end

    assign bus.R_Addr    = r_addr_q;
    assign bus.Pop       = pop;
    assign bus.Out_Data  = head_q;
    assign bus.Out_Valid = out_valid;
    assign bus.Empty     = empty;
    assign bus.Count     = count;

`ifdef BUFFER_READER_PTR_CHECK_EN
    logic ptr_err_q, ptr_err_d;

    always_comb begin
        ptr_err_d = ptr_err_q
                  | (!bus.Round && (bus.W_Addr < r_addr_q))
                  | ( bus.Round && (bus.W_Addr > r_addr_q));
    end

    always_ff @(posedge clk) begin
        if (!aclr_n) begin
            ptr_err_q <= 1'b0;
        end else begin
            ptr_err_q <= ptr_err_d;
        end
    end

    assign Ptr_Err = ptr_err_q;
`endif

endmodule

// File: tb/tb_buffer_reader.sv
// Self-checking bench for buffer_reader: memory/wrap-tracker model, vector table, scoreboard.
module tb_buffer_reader;
    localparam int BW    = 2;
    localparam int DW    = 8;
    localparam int DEPTH = 4;

    logic clk    = 1'b0;
    logic aclr_n = 1'b0;
    always #5 clk = ~clk;

    buffer_reader_if #(.BufferWidth(BW), .DataWidth(DW)) bus ();

`ifdef BUFFER_READER_PTR_CHECK_EN
    logic ptr_err;
`endif

    buffer_reader #(.BufferWidth(BW), .DataWidth(DW)) dut (
        .clk    (clk),
        .aclr_n (aclr_n),
        .bus    (bus)
`ifdef BUFFER_READER_PTR_CHECK_EN
        ,
        .Ptr_Err(ptr_err)
`endif
    );

    // Buffer memory and writer/wrap-tracker model
    logic [DW-1:0] mem [DEPTH];
    logic [BW-1:0] w_addr;
    logic          round;
    logic [DW-1:0] mem_rdata;

    logic          wr_en     = 1'b0;
    logic [DW-1:0] wr_data   = '0;
    logic          sw_en     = 1'b0;
    logic [BW-1:0] sw_addr   = '0;
    logic [DW-1:0] sw_data   = '0;
    logic          ld_en     = 1'b0;
    logic [BW-1:0] ld_w      = '0;
    logic          ld_round  = 1'b0;
    logic          out_ready = 1'b0;

    always @(posedge clk) begin
        if (sw_en) mem[sw_addr] <= sw_data;
        if (wr_en && aclr_n) mem[w_addr] <= wr_data;
        if (bus.Pop) mem_rdata <= mem[bus.R_Addr];
        if (!aclr_n) begin
            w_addr <= '0;
            round  <= 1'b0;
        end else begin
            if (wr_en) w_addr <= w_addr + BW'(1);
            if ((wr_en && w_addr == BW'(DEPTH - 1)) ^ (bus.Pop && bus.R_Addr == BW'(DEPTH - 1)))
                round <= ~round;
        end
        if (ld_en) begin
            w_addr <= ld_w;
            round  <= ld_round;
        end
    end

    assign bus.W_Addr    = w_addr;
    assign bus.Round     = round;
    assign bus.Mem_RData = mem_rdata;
    assign bus.Out_Ready = out_ready;

    int            n_checks = 0;
    int            n_fail   = 0;
    logic [DW-1:0] exp_q[$];
    int            rd_idx   = 0;
    int            pop_cnt  = 0;
    logic          prev_valid = 1'b0;
    logic          prev_ready = 1'b0;
    logic [DW-1:0] prev_data  = '0;

    typedef struct {
        logic [BW-1:0] w;
        logic          rnd;
        logic [BW:0]   cnt;
        logic          emp;
    } vec_t;

    vec_t vt[5];

    logic          cyc_pop [6];
    logic          cyc_val [6];
    logic [DW-1:0] cyc_dat [6];
    logic [BW-1:0] r_seq   [4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, req);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [BW-1:0] a, input logic [DW-1:0] d);
        sw_en   = 1'b1;
        sw_addr = a;
        sw_data = d;
        exp_q.push_back(d);
        step();
        sw_en = 1'b0;
    endtask

    task automatic load_ptr(input logic [BW-1:0] w, input logic r);
        ld_en    = 1'b1;
        ld_w     = w;
        ld_round = r;
        step();
        ld_en = 1'b0;
    endtask

    task automatic do_reset();
        wr_en     = 1'b0;
        out_ready = 1'b0;
        aclr_n    = 1'b0;
        step();
        step();
        rd_idx = exp_q.size();
    endtask

    task automatic drain(input int max_cycles);
        for (int i = 0; i < max_cycles; i++) begin
            if (rd_idx == exp_q.size()) break;
            step();
        end
        chk("drain_complete", rd_idx, exp_q.size());
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: actual running required finished");
        $fatal(1, "timeout");
    end

    initial begin
        // Output monitor: scoreboard compare and hold-while-stalled check
        fork
            forever begin
                @(negedge clk);
                if (!aclr_n) begin
                    prev_valid = 1'b0;
                end else begin
                    if (bus.Pop) pop_cnt++;
                    if (prev_valid && !prev_ready) begin
                        chk("hold_valid", bus.Out_Valid, 1);
                        chk("hold_data", bus.Out_Data, prev_data);
                    end
                    if (bus.Out_Valid && bus.Out_Ready) begin
                        if (rd_idx < exp_q.size()) begin
                            chk("sb_data", bus.Out_Data, exp_q[rd_idx]);
                            rd_idx++;
                        end else begin
                            n_checks++;
                            n_fail++;
                            $display("FAIL sb_extra: actual 0x%0h required no word", bus.Out_Data);
                        end
                    end
                    prev_valid = bus.Out_Valid;
                    prev_ready = bus.Out_Ready;
                    prev_data  = bus.Out_Data;
                end
            end
        join_none

        vt[0] = '{w: 2'd0, rnd: 1'b0, cnt: 3'd0, emp: 1'b1};
        vt[1] = '{w: 2'd1, rnd: 1'b0, cnt: 3'd1, emp: 1'b0};
        vt[2] = '{w: 2'd3, rnd: 1'b0, cnt: 3'd3, emp: 1'b0};
        vt[3] = '{w: 2'd0, rnd: 1'b1, cnt: 3'd4, emp: 1'b0};
        vt[4] = '{w: 2'd2, rnd: 1'b0, cnt: 3'd2, emp: 1'b0};

        cyc_pop = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        cyc_val = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        cyc_dat = '{8'h00, 8'h00, 8'h11, 8'h22, 8'h33, 8'h00};
        r_seq   = '{2'd1, 2'd2, 2'd3, 2'd0};

        // Reset state
        aclr_n = 1'b0;
        step();
        step();
        @(negedge clk);
        chk("rst_empty", bus.Empty, 1);
        chk("rst_count", bus.Count, 0);
        chk("rst_pop", bus.Pop, 0);
        chk("rst_valid", bus.Out_Valid, 0);
        chk("rst_raddr", bus.R_Addr, 0);
        chk("rst_odata", bus.Out_Data, 0);
        step();

        // Count/Empty vectors with R_Addr held at 0 by reset; Pop must stay low
        for (int i = 0; i < 5; i++) begin
            load_ptr(vt[i].w, vt[i].rnd);
            @(negedge clk);
            chk("vec_count", bus.Count, vt[i].cnt);
            chk("vec_empty", bus.Empty, vt[i].emp);
            chk("vec_pop_in_reset", bus.Pop, 0);
            chk("vec_raddr", bus.R_Addr, 0);
            step();
        end

        // Three queued words streamed back-to-back
        do_reset();
        preload(2'd0, 8'h11);
        preload(2'd1, 8'h22);
        preload(2'd2, 8'h33);
        load_ptr(2'd3, 1'b0);
        aclr_n    = 1'b1;
        out_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            chk("burst_pop", bus.Pop, cyc_pop[c]);
            chk("burst_valid", bus.Out_Valid, cyc_val[c]);
            if (cyc_val[c]) chk("burst_data", bus.Out_Data, cyc_dat[c]);
        end
        chk("burst_empty", bus.Empty, 1);
        step();
        drain(10);

        // Full buffer with consumer stalled: only two reads may be outstanding
        do_reset();
        preload(2'd0, 8'hA1);
        preload(2'd1, 8'hA2);
        preload(2'd2, 8'hA3);
        preload(2'd3, 8'hA4);
        load_ptr(2'd0, 1'b1);
        pop_cnt = 0;
        aclr_n  = 1'b1;
        repeat (6) step();
        chk("stall_pop_count", pop_cnt, 2);
        @(negedge clk);
        chk("stall_valid", bus.Out_Valid, 1);
        chk("stall_head", bus.Out_Data, 8'hA1);
        chk("stall_count", bus.Count, 2);
        chk("stall_raddr", bus.R_Addr, 2);
        chk("stall_pop", bus.Pop, 0);
        step();
        out_ready = 1'b1;
        drain(20);
        chk("stall_empty_after", bus.Empty, 1);

        // Wrap: R_Addr=1, W_Addr=1, Round=1 is a full buffer
        do_reset();
        preload(2'd0, 8'hB0);
        load_ptr(2'd1, 1'b0);
        aclr_n    = 1'b1;
        out_ready = 1'b1;
        drain(10);
        chk("wrap_raddr_start", bus.R_Addr, 1);
        preload(2'd1, 8'hB1);
        preload(2'd2, 8'hB2);
        preload(2'd3, 8'hB3);
        preload(2'd0, 8'hB4);
        load_ptr(2'd1, 1'b1);
        @(negedge clk);
        chk("wrap_count", bus.Count, 4);
        chk("wrap_empty", bus.Empty, 0);
        chk("wrap_pop", bus.Pop, 1);
        chk("wrap_raddr", bus.R_Addr, r_seq[0]);
        for (int i = 1; i < 4; i++) begin
            @(negedge clk);
            chk("wrap_pop", bus.Pop, 1);
            chk("wrap_raddr", bus.R_Addr, r_seq[i]);
        end
        step();
        drain(10);
        chk("wrap_empty_after", bus.Empty, 1);
        chk("wrap_raddr_end", bus.R_Addr, 1);

        // Reset the cycle after a Pop: in-flight word must be discarded
        do_reset();
        preload(2'd0, 8'h5A);
        preload(2'd1, 8'h6B);
        load_ptr(2'd2, 1'b0);
        aclr_n    = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        chk("midrst_pop", bus.Pop, 1);
        step();
        aclr_n = 1'b0;
        @(negedge clk);
        chk("midrst_pop_gated", bus.Pop, 0);
        step();
        step();
        rd_idx = exp_q.size();
        aclr_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("midrst_valid", bus.Out_Valid, 0);
            chk("midrst_raddr", bus.R_Addr, 0);
            chk("midrst_odata", bus.Out_Data, 0);
        end
        step();

        // Random writer pushes with random backpressure
        do_reset();
        aclr_n = 1'b1;
        for (int c = 0; c < 80; c++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            if ((bus.Count < 3'(DEPTH)) && ($urandom_range(0, 1) == 1)) begin
                wr_en   = 1'b1;
                wr_data = DW'($urandom);
                exp_q.push_back(wr_data);
            end else begin
                wr_en = 1'b0;
            end
            step();
        end
        wr_en     = 1'b0;
        out_ready = 1'b1;
        drain(20);
        chk("rand_empty_after", bus.Empty, 1);

`ifdef BUFFER_READER_PTR_CHECK_EN
        do_reset();
        chk("perr_reset", ptr_err, 0);
        preload(2'd0, 8'hC1);
        preload(2'd1, 8'hC2);
        load_ptr(2'd2, 1'b0);
        aclr_n    = 1'b1;
        out_ready = 1'b1;
        drain(10);
        out_ready = 1'b0;
        chk("perr_clean", ptr_err, 0);
        load_ptr(2'd1, 1'b0);
        chk("perr_not_yet", ptr_err, 0);
        step();
        chk("perr_set", ptr_err, 1);
        repeat (3) step();
        chk("perr_sticky", ptr_err, 1);
        do_reset();
        chk("perr_cleared", ptr_err, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
